conv_stream_driver: RTL and testbench

CONV_STREAM_DRIVER -- requirements
Module: conv_stream_driver

---
 rtl/conv_stream_driver.sv | 114 +++++++++++
 tb/tb_conv_stream_driver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_driver.sv
// Streams a loaded x buffer into a convolver and captures its results.
// Runs are started with a pulse; results are read back with one cycle latency.
module conv_stream_driver #(
  parameter int WIDTH = 8,
  parameter int LENX  = 8,
  parameter int LENF  = 4,
  parameter int ADDRX = 3,
  parameter int ADDRY = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_en,
  input  logic [ADDRX-1:0]        ld_addr,
  input  logic signed [WIDTH-1:0] ld_data,
  input  logic                    start,
  output logic signed [WIDTH-1:0] m_data_out_x,
  output logic                    m_valid_x,
  input  logic                    m_ready_x,
  input  logic signed [WIDTH-1:0] s_data_in_y,
  input  logic                    s_valid_y,
  output logic                    s_ready_y,
  input  logic [ADDRY-1:0]        rd_addr,
  output logic signed [WIDTH-1:0] rd_data,
  output logic                    busy,
  output logic                    done
);

  localparam int LENY = LENX - LENF + 1;
  localparam int TXW  = $clog2(LENX + 1);
  localparam int RXW  = $clog2(LENY + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [TXW-1:0] tx_cnt_q, tx_cnt_d;
  logic [RXW-1:0] rx_cnt_q, rx_cnt_d;

  logic signed [WIDTH-1:0] rd_data_q, rd_data_d;
  logic signed [WIDTH-1:0] xbuf_q [LENX];
  logic signed [WIDTH-1:0] ybuf_q [LENY];

  logic run, x_hs, y_hs, ld_we;

  always_comb begin
    run          = (state_q == RUN);
    m_valid_x    = run && (int'(tx_cnt_q) < LENX);
    s_ready_y    = run && (int'(rx_cnt_q) < LENY);
    m_data_out_x = '0;
    if (m_valid_x) m_data_out_x = xbuf_q[tx_cnt_q[ADDRX-1:0]];
    x_hs  = m_valid_x && m_ready_x;
    y_hs  = s_valid_y && s_ready_y;
    ld_we = ld_en && !run;
    busy  = run;
    done  = (state_q == DONE);
    rd_data = rd_data_q;
  end

  always_comb begin
    state_d  = state_q;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
        end
      end
      RUN: begin
        if (x_hs) tx_cnt_d = tx_cnt_q + TXW'(1);
        if (y_hs) rx_cnt_d = rx_cnt_q + RXW'(1);
        // Both counters already saturated: this edge closes the run.
        if (int'(tx_cnt_q) == LENX && int'(rx_cnt_q) == LENY)
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_data_d = '0;
    if (int'(rd_addr) < LENY) rd_data_d = ybuf_q[rd_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Buffers keep their contents across reset.
  always_ff @(posedge clk) begin
    if (ld_we) xbuf_q[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (y_hs) ybuf_q[rx_cnt_q[ADDRY-1:0]] <= s_data_in_y;
  end

endmodule

// File: tb/tb_conv_stream_driver.sv
// Directed bench for conv_stream_driver.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_conv_stream_driver;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_en;
  logic [2:0]        ld_addr;
  logic signed [7:0] ld_data;
  logic              start;
  logic signed [7:0] m_data_out_x;
  logic              m_valid_x;
  logic              m_ready_x;
  logic signed [7:0] s_data_in_y;
  logic              s_valid_y;
  logic              s_ready_y;
  logic [2:0]        rd_addr;
  logic signed [7:0] rd_data;
  logic              busy;
  logic              done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  conv_stream_driver dut (
    .clk          (clk),
    .reset        (reset),
    .ld_en        (ld_en),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .start        (start),
    .m_data_out_x (m_data_out_x),
    .m_valid_x    (m_valid_x),
    .m_ready_x    (m_ready_x),
    .s_data_in_y  (s_data_in_y),
    .s_valid_y    (s_valid_y),
    .s_ready_y    (s_ready_y),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input int d);
    ld_en   = 1'b1;
    ld_addr = 3'(a);
    ld_data = 8'(d);
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 20 && !done; c++) tick();
    chk(tag, done, 1);
  endtask

  task automatic rd_chk(input string tag, input int a, input int exp);
    rd_addr = 3'(a);
    tick();
    chk(tag, rd_data, exp);
  endtask

  task automatic finish_run(input int ybase);
    m_ready_x = 1'b1;
    s_valid_y = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      s_data_in_y = 8'(ybase + c);
      tick();
    end
    s_valid_y = 1'b0;
    m_ready_x = 1'b0;
    chk("finish_done", done, 1);
  endtask

  initial begin
    int xi, ry;
    reset = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; m_ready_x = 1'b0;
    s_valid_y = 1'b0; s_data_in_y = '0; rd_addr = '0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vx", m_valid_x, 0);
    chk("rst_ry", s_ready_y, 0);
    chk("rst_rd", rd_data, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    for (int i = 0; i < 8; i++) load(i, i + 1);

    // back-to-back run
    pulse_start();
    chk("s1_busy", busy, 1);
    m_ready_x = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_valid_y   = (i < 5);
      s_data_in_y = 8'(10 + i);
      chk("s1_vx", m_valid_x, 1);
      chk("s1_dx", m_data_out_x, i + 1);
      if (i < 5) chk("s1_ry", s_ready_y, 1);
      tick();
    end
    s_valid_y = 1'b0;
    chk("s1_vx_end", m_valid_x, 0);
    chk("s1_ry_end", s_ready_y, 0);
    tick();
    m_ready_x = 1'b0;
    chk("s1_done", done, 1);
    chk("s1_busy_end", busy, 0);
    for (int k = 0; k < 5; k++) rd_chk("s1_rd", k, 10 + k);
    rd_chk("s1_rd_oob5", 5, 0);
    rd_chk("s1_rd_oob7", 7, 0);
    chk("s1_done_hold", done, 1);

    // toggling x ready
    pulse_start();
    chk("s2_done_clr", done, 0);
    xi = 0;
    ry = 0;
    s_valid_y = 1'b1;
    for (int c = 0; c < 16; c++) begin
      m_ready_x   = c[0];
      s_data_in_y = 8'(20 + ry);
      chk("s2_vx", m_valid_x, 1);
      chk("s2_dx", m_data_out_x, xi + 1);
      chk("s2_ry", s_ready_y, (ry < 5) ? 1 : 0);
      if (m_ready_x) xi++;
      if (ry < 5) ry++;
      tick();
    end
    s_valid_y = 1'b0;
    m_ready_x = 1'b0;
    chk("s2_vx_end", m_valid_x, 0);
    wait_done("s2_done");
    rd_chk("s2_rd4", 4, 24);

    // y beats ahead of any x handshake
    pulse_start();
    m_ready_x = 1'b0;
    s_valid_y = 1'b1;
    for (int k = 0; k < 6; k++) begin
      s_data_in_y = 8'(30 + k);
      chk("s3_ry", s_ready_y, (k < 5) ? 1 : 0);
      chk("s3_dx_hold", m_data_out_x, 1);
      chk("s3_vx_hold", m_valid_x, 1);
      tick();
    end
    s_valid_y = 1'b0;
    m_ready_x = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("s3_dx", m_data_out_x, i + 1);
      tick();
    end
    m_ready_x = 1'b0;
    wait_done("s3_done");
    rd_chk("s3_rd0", 0, 30);
    rd_chk("s3_rd4", 4, 34);

    // final x and y in the same cycle
    pulse_start();
    m_ready_x = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_valid_y   = (i >= 3);
      s_data_in_y = 8'(40 + i - 3);
      tick();
    end
    s_valid_y = 1'b0;
    m_ready_x = 1'b0;
    chk("s4_vx_end", m_valid_x, 0);
    chk("s4_ry_end", s_ready_y, 0);
    tick();
    chk("s4_done", done, 1);
    rd_chk("s4_rd4", 4, 44);
    rd_chk("s4_rd0", 0, 40);

    // load and start ignored during a run
    pulse_start();
    m_ready_x = 1'b1;
    tick();
    m_ready_x = 1'b0;
    ld_en = 1'b1; ld_addr = 3'd0; ld_data = 8'sd99;
    start = 1'b1;
    tick();
    ld_en = 1'b0;
    start = 1'b0;
    chk("s5_no_restart", m_data_out_x, 2);
    chk("s5_busy", busy, 1);
    finish_run(50);

    // reset mid-run
    pulse_start();
    chk("s6_x0_kept", m_data_out_x, 1);
    m_ready_x = 1'b1;
    tick();
    tick();
    tick();
    chk("s6_dx3", m_data_out_x, 4);
    #1 reset = 1'b0;
    #1;
    chk("s6_vx_async", m_valid_x, 0);
    chk("s6_ry_async", s_ready_y, 0);
    chk("s6_busy_async", busy, 0);
    chk("s6_done_async", done, 0);
    chk("s6_rd_async", rd_data, 0);
    #1 reset = 1'b1;
    m_ready_x = 1'b0;
    tick();
    chk("s6_idle", busy, 0);
    pulse_start();
    chk("s6_resend_v", m_valid_x, 1);
    chk("s6_resend_d", m_data_out_x, 1);
    m_ready_x = 1'b1;
    tick();
    chk("s6_resend_d2", m_data_out_x, 2);
    m_ready_x = 1'b0;
    finish_run(60);
    rd_chk("s6_ybuf_kept", 4, 64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
